// File: rtl/eei.sv
// Execution-environment constants shared by the membus responders.
// Holds bus widths, the ACLINT memory-map window and register offsets,
// and a byte-merge helper used for masked 64-bit register writes.
package eei;

  localparam int XLEN              = 64;
  localparam int MEMBUS_DATA_WIDTH = 64;

  typedef logic [XLEN-1:0]                  Addr;
  typedef logic [63:0]                      UInt64;
  typedef logic [MEMBUS_DATA_WIDTH-1:0]     MemData;
  typedef logic [MEMBUS_DATA_WIDTH/8-1:0]   MemMask;
  typedef logic [15:0]                      AclintOff;

  localparam Addr MMAP_ACLINT_BEGIN = 64'h0000_0000_0200_0000;
  localparam Addr MMAP_ACLINT_END   = 64'h0000_0000_0200_ffff;

  localparam AclintOff MMAP_ACLINT_MSIP     = 16'h0000;
  localparam AclintOff MMAP_ACLINT_MTIMECMP = 16'h4000;
  localparam AclintOff MMAP_ACLINT_MTIME    = 16'h7ff8;
  localparam AclintOff MMAP_ACLINT_SETSSIP  = 16'h8000;

  localparam int TICK_DIV_DEFAULT = 1;

  // Bytes with their enable set come from new_v, the rest keep old_v.
  function automatic UInt64 merge_bytes(UInt64 old_v, UInt64 new_v, MemMask m);
    UInt64 r;
    r = old_v;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/aclint_memory_if.sv
// Membus request/response bundle between a bus master and a responder.
//   valid/ready : request handshake, accepted when both are high
//   addr/wen/wdata/wmask : request payload
//   rvalid/rdata : one response per accepted request, one cycle later
interface aclint_memory_if;
  import eei::*;

  logic   valid;
  logic   ready;
  Addr    addr;
  logic   wen;
  MemData wdata;
  MemMask wmask;
  logic   rvalid;
  MemData rdata;

  modport master (
    output valid, addr, wen, wdata, wmask,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, addr, wen, wdata, wmask,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/aclint_mtime_counter.sv
// Prescaled mtime counter.
//   clk, rst : clock, async active-high reset
//   wen      : load mtime with wdata this cycle (overrides an increment)
//   wdata    : already byte-merged mtime value
//   tick     : high in the cycle where mtime would increment
//   mtime    : current mtime register
module aclint_mtime_counter
  import eei::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  wen,
  input  UInt64 wdata,
  output logic  tick,
  output UInt64 mtime
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick_cnt;

  assign tick = (tick_cnt == LAST);

  // The prescaler free-runs; bus writes to mtime never disturb it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt <= '0;
    end else if (tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtime <= '0;
    end else if (wen) begin
      mtime <= wdata;
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

endmodule

// File: rtl/aclint_memory.sv
// ACLINT responder for hart 0 on the 64-bit membus.
//   clk, rst   : clock, async active-high reset
//   bus        : membus slave (no backpressure, 1-cycle response)
//   mtime_o    : current mtime, feeds the time CSR
//   msip       : machine software interrupt pending
//   mtip       : machine timer interrupt pending, mtime >= mtimecmp
//   ssip_pulse : one-cycle request to set mip.SSIP
module aclint_memory
  import eei::*;
#(
  parameter int  TICK_DIV  = TICK_DIV_DEFAULT,
  parameter Addr BASE_ADDR = MMAP_ACLINT_BEGIN
) (
  input  logic              clk,
  input  logic              rst,
  aclint_memory_if.slave    bus,
  output UInt64             mtime_o,
  output logic              msip,
  output logic              mtip,
  output logic              ssip_pulse
);

  UInt64    mtime;
  UInt64    mtimecmp;
  AclintOff off;
  logic     accept;
  logic     wr;
  logic     wr_mtime;
  UInt64    mtime_wdata;
  UInt64    rd_val;
  logic     tick;

  // Only the low 16 bits of the offset select a register; the window
  // decode upstream guarantees the upper bits.
  assign off    = bus.addr[15:0] - BASE_ADDR[15:0];
  assign accept = bus.valid && bus.ready;
  assign wr     = accept && bus.wen;

  assign bus.ready = ~rst;

  assign wr_mtime    = wr && (off == MMAP_ACLINT_MTIME);
  assign mtime_wdata = merge_bytes(mtime, bus.wdata, bus.wmask);

  aclint_mtime_counter #(
    .TICK_DIV (TICK_DIV)
  ) u_mtime (
    .clk   (clk),
    .rst   (rst),
    .wen   (wr_mtime),
    .wdata (mtime_wdata),
    .tick  (tick),
    .mtime (mtime)
  );

  assign mtime_o = mtime;
  assign mtip    = (mtime >= mtimecmp);

  always_comb begin
    rd_val = '0;
    case (off)
      MMAP_ACLINT_MSIP:     rd_val = {63'b0, msip};
      MMAP_ACLINT_MTIMECMP: rd_val = mtimecmp;
      MMAP_ACLINT_MTIME:    rd_val = mtime;
      default:              rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mtimecmp <= '1;
      msip     <= 1'b0;
    end else if (wr) begin
      if (off == MMAP_ACLINT_MTIMECMP) begin
        mtimecmp <= merge_bytes(mtimecmp, bus.wdata, bus.wmask);
      end
      if (off == MMAP_ACLINT_MSIP && bus.wmask[0]) begin
        msip <= bus.wdata[0];
      end
    end
  end

  // Response path; ssip_pulse clears itself the cycle after it fires.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rvalid <= 1'b0;
      bus.rdata  <= '0;
      ssip_pulse <= 1'b0;
    end else begin
      bus.rvalid <= accept;
      bus.rdata  <= (accept && !bus.wen) ? rd_val : '0;
      ssip_pulse <= wr && (off == MMAP_ACLINT_SETSSIP)
                    && bus.wmask[0] && bus.wdata[0];
    end
  end

  // tick only matters inside the counter; kept visible for debug.
  logic unused_tick;
  assign unused_tick = tick;

endmodule

// File: doc/aclint_memory.md
Name: aclint_memory

Overview:
Memory-mapped ACLINT responder for hart 0. It sits on the 64-bit membus behind the address decoder, at the window MMAP_ACLINT_BEGIN..MMAP_ACLINT_END. It holds mtime, mtimecmp, MSIP and SETSSIP, and drives the interrupt-pending lines that the core's CSR unit turns into MACHINE_TIMER/MACHINE_SOFTWARE/SUPERVISOR_SOFTWARE interrupt causes.

Parameters:
TICK_DIV, 1, clk cycles per mtime increment (>=1)
BASE_ADDR, MMAP_ACLINT_BEGIN, base address subtracted from bus_addr to form the register offset

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
bus_valid  input  1  request valid
bus_ready  output  1  request accepted when valid&&ready
bus_addr  input  XLEN  byte address, 8-byte aligned
bus_wen  input  1  1=write, 0=read
bus_wdata  input  MEMBUS_DATA_WIDTH  write data
bus_wmask  input  MEMBUS_DATA_WIDTH/8  byte enables for writes
bus_rvalid  output  1  response valid, one per accepted request
bus_rdata  output  MEMBUS_DATA_WIDTH  read data; 0 for writes
mtime_o  output  64  current mtime (feeds time CSR)
msip  output  1  machine software interrupt pending
mtip  output  1  machine timer interrupt pending
ssip_pulse  output  1  one-cycle set-request for mip.SSIP

Behaviour:
- Reset values (asynchronous on rst=1): mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, tick_cnt=0, bus_rvalid=0, bus_rdata=0, ssip_pulse=0. bus_ready=0 while rst=1. With these values mtip=0.
- Handshake: bus_ready=1 every cycle out of reset, so there is no backpressure. A request accepted in cycle N gives bus_rvalid=1 in cycle N+1 with registered bus_rdata. Back-to-back requests give back-to-back responses.
- Decode: off = bus_addr - BASE_ADDR, truncated to 16 bits.
  - off=MMAP_ACLINT_MSIP (0): read returns {63'b0,msip}; a write with wmask[0]=1 sets msip=wdata[0]; other bits are ignored.
  - off=MMAP_ACLINT_MTIMECMP (0x4000): 64-bit read/write, byte-merged per wmask.
  - off=MMAP_ACLINT_MTIME (0x7ff8): 64-bit read/write, byte-merged per wmask.
  - off=MMAP_ACLINT_SETSSIP (0x8000): read returns 0; a write with wmask[0]=1 and wdata[0]=1 sets ssip_pulse=1 for exactly cycle N+1; writing 0 has no effect.
  - Any other offset: read returns 0, write is ignored, and the response is still issued. There is no error response.
- Read-during-write: a read in cycle N returns register values as of the start of cycle N. Writes take effect at the end of cycle N.
- Timer:
  - tick_cnt counts 0..TICK_DIV-1. When tick_cnt==TICK_DIV-1, tick_cnt returns to 0 and mtime increments by 1, modulo 2^64: 64'hFFFF..FF wraps to 0.
  - If a bus write to MTIME occurs in the same cycle as an increment, the write wins: mtime takes the merged value and skips that increment. tick_cnt is not affected by MTIME writes.
- mtip is combinational: (mtime >= mtimecmp), unsigned, from the current registers. It deasserts the cycle after a write that raises mtimecmp above mtime.
- mtime_o is equal to the mtime register.
- If rst is asserted mid-transaction, the pending response is dropped (bus_rvalid=0) and all state goes to its reset values.

Decomposition:
- Package eei gains:
  - localparam TICK_DIV_DEFAULT
  - typedef logic [MEMBUS_DATA_WIDTH/8-1:0] MemMask
  - a helper function that byte-merges old/new UInt64 under a MemMask
- Existing MMAP_ACLINT_* constants are the only source of offsets.
- One sub-module: aclint_mtime_counter, covering the prescaler plus the mtime register with write-port priority. It exposes mtime, a write enable, merged write data and the tick.

Test Plan:
- Reset, then read 0x200_4000 -> rdata=64'hFFFF_FFFF_FFFF_FFFF one cycle later; mtip=0, msip=0, mtime_o=0 at the first post-reset edge.
- TICK_DIV=1: write mtimecmp=0x10 (wmask 0xFF) -> mtip rises in the cycle mtime_o==0x10; write mtimecmp=0x100 -> mtip=0 next cycle.
- Write MTIME wdata=0x1122_3344_5566_7788, wmask=0x0F, when mtime=0x20 -> mtime becomes 0x0000_0000_5566_7788 and increments from there; the same-cycle tick is skipped.
- Write MSIP wdata=0xFFFF_FFFE -> msip stays 0; write 1 -> msip=1 next cycle; read returns 1; write 0 -> msip=0.
- Write SETSSIP wdata=1 -> ssip_pulse high exactly one cycle; a read of 0x200_8000 returns 0; writing 0 gives no pulse.
- Read unmapped 0x200_1000 -> rvalid=1, rdata=0; set mtime=64'hFFFF_FFFF_FFFF_FFFE -> reaches 0 after two ticks; assert rst with a request outstanding -> rvalid=0 the next cycle.
